// File: rtl/exception_ctrl.sv
// Exception/interrupt controller: captures cause and return PC, then issues
// one-cycle fetch redirects to the handler vector (take) or back to ERR (eret).
module exception_ctrl #(
  parameter int unsigned N    = 64,
  parameter logic [N-1:0] VBAR = 64'h0000_0000_0000_D800
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ExcInvOp_i,
  input  logic         ExcMemAbort_i,
  input  logic         ExtIRQ_i,
  input  logic         ERet_i,
  input  logic [N-1:0] ExcPC_i,
  output logic         EProc_F,
  output logic [N-1:0] EVAddr_F,
  output logic         Flush,
  output logic         ExcAck,
  output logic [N-1:0] ERR,
  output logic [3:0]   ESR,
  output logic         InHandler
);

  localparam logic [3:0] ESR_NONE  = 4'b0000;
  localparam logic [3:0] ESR_INVOP = 4'b0001;
  localparam logic [3:0] ESR_ABORT = 4'b0010;
  localparam logic [3:0] ESR_IRQ   = 4'b0011;
  localparam logic [3:0] ESR_DBL   = 4'b1111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   err_n;
  logic [3:0]     esr_n;
  logic           eproc_n;
  logic [N-1:0]   evaddr_n;
  logic           ack_n;
  logic           inhandler_n;

  // Handler entry address for a given syndrome; offsets wrap at N bits.
  function automatic logic [N-1:0] vec_addr(input logic [3:0] cause);
    logic [N-1:0] addr;
    case (cause)
      ESR_IRQ: addr = VBAR + N'(12'h080);
      ESR_DBL: addr = VBAR + N'(12'h100);
      default: addr = VBAR;
    endcase
    return addr;
  endfunction

  // Highest-priority pending cause seen from IDLE (abort > invop > irq).
  function automatic logic [3:0] pick_cause(input logic abort, input logic invop,
                                            input logic irq);
    logic [3:0] c;
    if (abort)      c = ESR_ABORT;
    else if (invop) c = ESR_INVOP;
    else if (irq)   c = ESR_IRQ;
    else            c = ESR_NONE;
    return c;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state, next ERR/ESR and the Moore outputs of the next state.
  always_comb begin
    state_n = state;
    err_n   = ERR;
    esr_n   = ESR;
    unique case (state)
      IDLE: begin
        if (ExcMemAbort_i || ExcInvOp_i || ExtIRQ_i) begin
          err_n   = ExcPC_i;
          esr_n   = pick_cause(ExcMemAbort_i, ExcInvOp_i, ExtIRQ_i);
          state_n = TAKE;
        end
      end
      TAKE: state_n = HANDLER;
      HANDLER: begin
        // IRQs are masked here; a sync exception beats a simultaneous ERET.
        if (ExcMemAbort_i || ExcInvOp_i) begin
          esr_n   = ESR_DBL;
          state_n = TAKE;
        end else if (ERet_i) begin
          state_n = RETURN;
        end
      end
      RETURN: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    eproc_n     = (state_n == TAKE) || (state_n == RETURN);
    inhandler_n = (state_n != IDLE);
    ack_n       = (state_n == TAKE) && (esr_n == ESR_IRQ);
    evaddr_n    = '0;
    if (state_n == TAKE)        evaddr_n = vec_addr(esr_n);
    else if (state_n == RETURN) evaddr_n = err_n;
  end

  // Registered outputs and saved exception context.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ERR       <= '0;
      ESR       <= ESR_NONE;
      EProc_F   <= 1'b0;
      EVAddr_F  <= '0;
      Flush     <= 1'b0;
      ExcAck    <= 1'b0;
      InHandler <= 1'b0;
    end else begin
      ERR       <= err_n;
      ESR       <= esr_n;
      EProc_F   <= eproc_n;
      EVAddr_F  <= evaddr_n;
      Flush     <= eproc_n;
      ExcAck    <= ack_n;
      InHandler <= inhandler_n;
    end
  end

endmodule
